// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester command/response and APB master signal bundle
interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WD = 8,
    parameter int DATA_WD = 8,
    parameter int STRB_WD = 2,
    parameter int PROT_WD = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_write;
    logic [NUM_REQ*ADDR_WD-1:0] req_addr;
    logic [NUM_REQ*DATA_WD-1:0] req_wdata;
    logic [NUM_REQ*PROT_WD-1:0] req_prot;
    logic [NUM_REQ*STRB_WD-1:0] req_strb;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [DATA_WD-1:0]         rsp_rdata;
    logic                       rsp_err;
    logic                       a_psel;
    logic                       a_penable;
    logic                       a_pwrite;
    logic [ADDR_WD-1:0]         a_paddr;
    logic [DATA_WD-1:0]         a_pwdata;
    logic [PROT_WD-1:0]         a_pprot;
    logic [STRB_WD-1:0]         a_pstrb;
    logic [DATA_WD-1:0]         a_prdata;
    logic                       a_pready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_prot, req_strb,
        input  a_prdata, a_pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_pprot, a_pstrb
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_prot, req_strb,
        output a_prdata, a_pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_pprot, a_pstrb
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter onto one APB master port; APB_TIMEOUT_EN adds an ACCESS wait limit
module apb_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WD     = 8,
    parameter int DATA_WD     = 8,
    parameter int STRB_WD     = 2,
    parameter int PROT_WD     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 a_pclk,
    input  logic                 a_prst_n,
    apb_master_arbiter_if.master bus
);
    localparam int IDX_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject parameter sets the arbiter is not built for
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("apb_master_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_WD-1:0]   ptr_q;
    logic [IDX_WD-1:0]   win_idx;
    logic                win_found;
    logic                accept;
    logic                xfer_abort;
    logic                xfer_end;

    logic                sel_write;
    logic [ADDR_WD-1:0]  sel_addr;
    logic [DATA_WD-1:0]  sel_wdata;
    logic [PROT_WD-1:0]  sel_prot;
    logic [STRB_WD-1:0]  sel_strb;

    logic                a_pwrite_q;
    logic [ADDR_WD-1:0]  a_paddr_q;
    logic [DATA_WD-1:0]  a_pwdata_q;
    logic [PROT_WD-1:0]  a_pprot_q;
    logic [STRB_WD-1:0]  a_pstrb_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_WD-1:0]  rsp_rdata_q;

    // Round-robin search: offset k from the last grant, first valid requester wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && bus.req_valid[i] &&
                    ptr_q == IDX_WD'((i + NUM_REQ - k) % NUM_REQ)) begin
                    win_found = 1'b1;
                    win_idx   = IDX_WD'(i);
                end
            end
        end
    end

    // Mux the winner's command fields out of the packed request buses
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_prot  = '0;
        sel_strb  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_WD'(i)) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*ADDR_WD +: ADDR_WD];
                sel_wdata = bus.req_wdata[i*DATA_WD +: DATA_WD];
                sel_prot  = bus.req_prot[i*PROT_WD +: PROT_WD];
                sel_strb  = bus.req_strb[i*STRB_WD +: STRB_WD];
            end
        end
    end

    assign accept   = (state_q == ST_IDLE) && win_found;
    assign xfer_end = (state_q == ST_ACCESS) && (bus.a_pready || xfer_abort);

`ifdef APB_TIMEOUT_EN
    localparam int TO_WD = $clog2(TIMEOUT_CYC + 1);
    logic [TO_WD-1:0] to_cnt_q;
    logic             rsp_err_q;

    // Count ACCESS cycles spent waiting; restarts whenever a new transfer sets up
    always_ff @(posedge a_pclk) begin
        if (!a_prst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !bus.a_pready) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // A late pready on the limit cycle still completes normally
    assign xfer_abort = (state_q == ST_ACCESS) && !bus.a_pready &&
                        (to_cnt_q == TO_WD'(TIMEOUT_CYC - 1));

    // Error flag travels with the response pulse
    always_ff @(posedge a_pclk) begin
        if (!a_prst_n) begin
            rsp_err_q <= 1'b0;
        end else if (xfer_end) begin
            rsp_err_q <= xfer_abort;
        end else begin
            rsp_err_q <= 1'b0;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign xfer_abort  = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge a_pclk) begin
        if (!a_prst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one transfer at a time, SETUP always lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (bus.a_pready || xfer_abort) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: grant only while idle, APB phase strobes
    always_comb begin
        bus.req_ready = '0;
        bus.a_psel    = 1'b0;
        bus.a_penable = 1'b0;
        case (state_q)
            ST_IDLE:   if (win_found) bus.req_ready = NUM_REQ'(1) << win_idx;
            ST_SETUP:  bus.a_psel = 1'b1;
            ST_ACCESS: begin
                bus.a_psel    = 1'b1;
                bus.a_penable = 1'b1;
            end
            default:   bus.req_ready = '0;
        endcase
    end

    // Latch the granted command into the APB output registers and remember the winner
    always_ff @(posedge a_pclk) begin
        if (!a_prst_n) begin
            ptr_q      <= IDX_WD'(NUM_REQ - 1);
            a_pwrite_q <= 1'b0;
            a_paddr_q  <= '0;
            a_pwdata_q <= '0;
            a_pprot_q  <= '0;
            a_pstrb_q  <= '0;
        end else if (accept) begin
            ptr_q      <= win_idx;
            a_pwrite_q <= sel_write;
            a_paddr_q  <= sel_addr;
            a_pwdata_q <= sel_wdata;
            a_pprot_q  <= sel_prot;
            a_pstrb_q  <= sel_strb;
        end
    end

    // One-cycle response pulse to the owner of the finished transfer
    always_ff @(posedge a_pclk) begin
        if (!a_prst_n) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (xfer_end) begin
                rsp_valid_q <= NUM_REQ'(1) << ptr_q;
                rsp_rdata_q <= bus.a_pready ? bus.a_prdata : '0;
            end
        end
    end

    assign bus.a_pwrite  = a_pwrite_q;
    assign bus.a_paddr   = a_paddr_q;
    assign bus.a_pwdata  = a_pwdata_q;
    assign bus.a_pprot   = a_pprot_q;
    assign bus.a_pstrb   = a_pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int PW = 4;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_arbiter_if #(.NUM_REQ(N), .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW)) bus ();

    apb_master_arbiter #(.NUM_REQ(N), .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW),
                         .TIMEOUT_CYC(TO)) dut (
        .a_pclk  (clk),
        .a_prst_n(rst_n),
        .bus     (bus)
    );

    logic [N-1:0]  r_valid = '0;
    logic [N-1:0]  r_write = '0;
    logic [AW-1:0] r_addr  [N];
    logic [DW-1:0] r_wdata [N];
    logic [PW-1:0] r_prot  [N];
    logic [SW-1:0] r_strb  [N];

    assign bus.req_valid = r_valid;
    assign bus.req_write = r_write;

    always_comb begin
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_prot  = '0;
        bus.req_strb  = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = r_addr[i];
            bus.req_wdata[i*DW +: DW] = r_wdata[i];
            bus.req_prot[i*PW +: PW]  = r_prot[i];
            bus.req_strb[i*SW +: SW]  = r_strb[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction model: age counts cycles since the command was accepted
    bit            model_on = 1'b0;
    int            m_ptr    = N - 1;
    int            m_age    = 0;
    int            m_waits  = 0;
    int            m_g      = 0;
    logic          m_write  = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [PW-1:0] m_prot   = '0;
    logic [SW-1:0] m_strb   = '0;
    bit            m_rsp    = 1'b0;
    int            m_rsp_idx = 0;
    logic [DW-1:0] m_rdata  = '0;
    bit            m_err    = 1'b0;

    always @(negedge clk) begin : model_cmp
        int           w;
        logic [N-1:0] exp_rdy;
        bit           nxt_rsp;
        w = pick(bus.req_valid, m_ptr);
        if (model_on) begin
            exp_rdy = (m_age == 0 && w >= 0) ? (N'(1) << w) : '0;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("a_psel", bus.a_psel, m_age != 0);
            chk("a_penable", bus.a_penable, m_age >= 2);
            chk("a_pwrite", bus.a_pwrite, m_write);
            chk("a_paddr", bus.a_paddr, m_addr);
            chk("a_pwdata", bus.a_pwdata, m_wdata);
            chk("a_pprot", bus.a_pprot, m_prot);
            chk("a_pstrb", bus.a_pstrb, m_strb);
            chk("rsp_valid", bus.rsp_valid, m_rsp ? (N'(1) << m_rsp_idx) : '0);
            if (m_rsp) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk("rsp_err", bus.rsp_err, m_err);
            end
        end
        nxt_rsp = 1'b0;
        if (!rst_n) begin
            model_on = 1'b1;
            m_ptr = N - 1; m_age = 0; m_waits = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0; m_prot = '0; m_strb = '0;
            m_rdata = '0; m_err = 1'b0;
        end else if (m_age == 0) begin
            if (w >= 0) begin
                m_g = w; m_ptr = w; m_age = 1;
                m_write = r_write[w]; m_addr = r_addr[w]; m_wdata = r_wdata[w];
                m_prot = r_prot[w]; m_strb = r_strb[w];
            end
        end else if (m_age == 1) begin
            m_age = 2; m_waits = 0;
        end else if (bus.a_pready) begin
            nxt_rsp = 1'b1; m_rsp_idx = m_g; m_rdata = bus.a_prdata; m_err = 1'b0; m_age = 0;
        end else begin
            m_waits++;
`ifdef APB_TIMEOUT_EN
            if (m_waits == TO) begin
                nxt_rsp = 1'b1; m_rsp_idx = m_g; m_rdata = '0; m_err = 1'b1; m_age = 0;
            end
`endif
        end
        m_rsp = nxt_rsp;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_valid[i] = 1'b1;
        r_write[i] = wr;
        r_addr[i]  = a;
        r_wdata[i] = d;
        r_prot[i]  = 4'h2;
        r_strb[i]  = 2'b11;
    endtask

    task automatic rnd_cmd(input int i);
        r_valid[i] = 1'b1;
        r_write[i] = 1'($urandom_range(0, 1));
        r_addr[i]  = AW'($urandom);
        r_wdata[i] = DW'($urandom);
        r_prot[i]  = PW'($urandom);
        r_strb[i]  = SW'($urandom);
    endtask

    task automatic drain();
        r_valid = '0;
        bus.a_pready = 1'b1;
        repeat (4) nxt();
    endtask

    initial begin
        logic [N-1:0] acc;
        int           pen_cnt;
        int           grants[$];
        int           exp_g[7];
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_prot[i] = '0; r_strb[i] = '0;
        end
        bus.a_pready = 1'b1;
        bus.a_prdata = '0;
        repeat (3) nxt();

        // reset state
        smp();
        chk("rst_psel", bus.a_psel, 1'b0);
        chk("rst_penable", bus.a_penable, 1'b0);
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_paddr", bus.a_paddr, 8'h00);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("model_rst_ptr", m_ptr, 3);

        // single zero-wait write from requester 0
        nxt(); rst_n = 1'b1;
        set_cmd(0, 1'b1, 8'h12, 8'hA5);
        smp(); chk("t1_ready", bus.req_ready, 4'b0001);
        nxt(); r_valid[0] = 1'b0;
        smp();
        chk("t1_setup_psel", bus.a_psel, 1'b1);
        chk("t1_setup_penable", bus.a_penable, 1'b0);
        chk("t1_setup_paddr", bus.a_paddr, 8'h12);
        chk("t1_setup_pwdata", bus.a_pwdata, 8'hA5);
        chk("t1_setup_pwrite", bus.a_pwrite, 1'b1);
        nxt(); smp();
        chk("t1_access_penable", bus.a_penable, 1'b1);
        chk("t1_access_paddr", bus.a_paddr, 8'h12);
        nxt(); smp();
        chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t1_psel_done", bus.a_psel, 1'b0);

        // read with three wait states from requester 1
        nxt(); set_cmd(1, 1'b0, 8'h40, 8'h00); bus.a_pready = 1'b0;
        smp(); chk("t2_ready", bus.req_ready, 4'b0010);
        nxt(); r_valid[1] = 1'b0;
        pen_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            nxt(); bus.a_pready = (c == 3); bus.a_prdata = 8'h5C;
            smp();
            if (bus.a_penable) pen_cnt++;
            if (bus.a_pready) break;
        end
        nxt(); bus.a_pready = 1'b1;
        smp();
        chk("t2_penable_cycles", pen_cnt, 4);
        chk("t2_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("t2_rsp_rdata", bus.rsp_rdata, 8'h5C);

        // fairness with all requesters held from reset
        nxt(); rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_cmd(i, 1'(i % 2), AW'(8'h80 + i), DW'(i));
        nxt(); rst_n = 1'b1;
        grants.delete();
        for (int c = 0; c < 80 && grants.size() < 7; c++) begin
            smp();
            if (bus.req_ready != '0) grants.push_back(oh2idx(bus.req_ready));
            nxt();
            if (grants.size() >= 5) r_valid = 4'b0101;
        end
        exp_g = '{0, 1, 2, 3, 0, 2, 0};
        chk("fair_count", grants.size(), 7);
        for (int k = 0; k < 7; k++) chk($sformatf("fair_grant%0d", k), (k < grants.size()) ? grants[k] : -1, exp_g[k]);
        chk("model_fair_ptr", m_ptr, 0);
        drain();

        // response to requester 1 and grant to requester 3 in the same cycle
        set_cmd(1, 1'b1, 8'h33, 8'h44);
        smp(); chk("t4_ready1", bus.req_ready, 4'b0010);
        nxt(); r_valid[1] = 1'b0; set_cmd(3, 1'b0, 8'h77, 8'h00);
        nxt(); nxt(); smp();
        chk("t4_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("t4_ready3", bus.req_ready, 4'b1000);
        nxt(); r_valid[3] = 1'b0;
        drain();

        // reset in the middle of ACCESS
        set_cmd(1, 1'b0, 8'h21, 8'h00); bus.a_pready = 1'b0;
        smp(); chk("t5_ready", bus.req_ready, 4'b0010);
        nxt(); r_valid[1] = 1'b0;
        nxt(); smp(); chk("t5_in_access", bus.a_penable, 1'b1);
        nxt(); rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(8'hC0 + i), 8'h00);
        nxt(); rst_n = 1'b1;
        smp();
        chk("t5_psel", bus.a_psel, 1'b0);
        chk("t5_penable", bus.a_penable, 1'b0);
        chk("t5_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("t5_ptr_reset", bus.req_ready, 4'b0001);
        bus.a_pready = 1'b1;
        drain();

`ifdef APB_TIMEOUT_EN
        // pready stuck low until the wait limit
        set_cmd(2, 1'b0, 8'h55, 8'h00); bus.a_pready = 1'b0; bus.a_prdata = 8'hEE;
        smp();
        nxt(); r_valid[2] = 1'b0;
        pen_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            nxt(); smp();
            if (bus.rsp_valid != '0) break;
            if (bus.a_penable) pen_cnt++;
        end
        chk("t6_penable_cycles", pen_cnt, TO);
        chk("t6_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("t6_rsp_err", bus.rsp_err, 1'b1);
        chk("t6_rsp_rdata", bus.rsp_rdata, 8'h00);
        bus.a_pready = 1'b1;
        set_cmd(0, 1'b1, 8'h66, 8'h99);
        nxt(); r_valid[0] = 1'b0;
        nxt(); nxt(); smp();
        chk("t6_next_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t6_next_rsp_err", bus.rsp_err, 1'b0);
        drain();
`endif

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            smp();
            acc = bus.req_valid & bus.req_ready;
            nxt();
            rst_n = ($urandom_range(0, 399) != 0);
            bus.a_pready = ($urandom_range(0, 3) != 0);
            bus.a_prdata = DW'($urandom);
            for (int i = 0; i < N; i++) begin
                if (r_valid[i]) begin
                    if (acc[i]) begin
                        if ($urandom_range(0, 1) == 1) rnd_cmd(i);
                        else r_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        r_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rnd_cmd(i);
                end
            end
        end
        rst_n = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the a-side APB master port of the asynchronous bridge between NUM_REQ local requesters.
- Each requester presents a simple valid/ready command and receives a one-cycle response pulse.
- Round-robin arbitration; one APB transfer in flight at a time; runs entirely in the a_pclk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WD, 8, APB address width
DATA_WD, 8, APB data width
STRB_WD, 2, APB write strobe width
PROT_WD, 4, APB protection width
TIMEOUT_CYC, 16, ACCESS-phase wait limit in cycles; used only when APB_TIMEOUT_EN is defined

Ports:
a_pclk  in  1  clock; all logic on rising edge
a_prst_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept (one-hot or zero)
req_write  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WD  packed addresses; requester i at [i*ADDR_WD +: ADDR_WD]
req_wdata  in  NUM_REQ*DATA_WD  packed write data
req_prot  in  NUM_REQ*PROT_WD  packed pprot
req_strb  in  NUM_REQ*STRB_WD  packed pstrb
rsp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester
rsp_rdata  out  DATA_WD  read data; valid while rsp_valid is non-zero
rsp_err  out  1  timeout flag; valid while rsp_valid is non-zero
a_psel, a_penable, a_pwrite  out  1 each  APB master controls to bridge
a_paddr  out  ADDR_WD  APB address
a_pwdata  out  DATA_WD  APB write data
a_pprot  out  PROT_WD  APB protection
a_pstrb  out  STRB_WD  APB strobes
a_prdata  in  DATA_WD  APB read data from bridge
a_pready  in  1  APB ready from bridge

Behaviour:
- Reset (a_prst_n low at a rising edge): all outputs 0; FSM goes to IDLE; rr pointer set to NUM_REQ-1, so requester 0 has first priority. Reset mid-transfer drops a_psel/a_penable at that edge; no rsp_valid is issued.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational and one-hot to the winner g when any req_valid is set.
  - Winner g is the first set req_valid searching from (ptr+1) mod NUM_REQ upward, with wrap-around.
  - On accept (valid&ready): latch write/addr/wdata/prot/strb of g into the APB output registers, set ptr=g, and go to SETUP.
- SETUP: a_psel=1, a_penable=0. Always goes to ACCESS next cycle.
- ACCESS:
  - a_psel=1, a_penable=1; hold until a_pready=1.
  - On a_pready: capture a_prdata into rsp_rdata (for writes capture too; requester ignores it).
  - Next cycle: rsp_valid[g]=1 for exactly one cycle, rsp_err=0, a_psel=a_penable=0, FSM in IDLE.
- Latency: accept at edge T; SETUP during T+1; ACCESS during T+2; zero-wait pready gives rsp_valid during T+3, where the next accept is also possible. Minimum transfer spacing is 3 cycles.
- APB address/control/data outputs hold their values from SETUP through the end of ACCESS. After the transfer they keep their last value, with a_psel=0.
- Requesters hold command fields stable while req_valid=1. Dropping req_valid before accept is legal and issues nothing.
- Requesters not granted see req_ready=0 and are never lost; with continuous requests each requester waits at most NUM_REQ-1 transfers.
- req_ready is 0 in SETUP and ACCESS.
- rsp_valid and req_ready to different requesters may assert in the same IDLE cycle.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with a_pready=0.
  - If it reaches TIMEOUT_CYC, the transfer is abandoned: a_psel/a_penable go 0 the next cycle, rsp_valid[g]=1 with rsp_err=1 and rsp_rdata=0, and the FSM returns to IDLE.
  - a_pready arriving in the same cycle as the limit wins (normal completion, rsp_err=0).
- Not defined: no counter; ACCESS waits indefinitely; rsp_err is constant 0.

Test Plan:
- Single write: req 0 with addr 0x12, wdata 0xA5, pready tied 1 → APB SETUP at T+1, ACCESS at T+2 with paddr 0x12 and pwdata 0xA5; rsp_valid=4'b0001 at T+3.
- Read with wait states: req 1 reads addr 0x40, pready low 3 ACCESS cycles then high with prdata 0x5C → penable high 4 cycles; rsp_rdata 0x5C with rsp_valid=4'b0010.
- Fairness: all four req_valid held from reset → grant order 0,1,2,3,0; then only req 2 and 0 pending after grant 2 → next grant 0.
- Simultaneous response/accept: req 3 pending while req 1 completes → rsp_valid[1] and req_ready[3] in the same cycle.
- Reset mid-ACCESS: a_prst_n low during ACCESS → next edge psel=penable=0, rsp_valid=0, rr pointer back to NUM_REQ-1.
- APB_TIMEOUT_EN with TIMEOUT_CYC=16 and pready stuck 0 → after 16 ACCESS cycles psel drops; rsp_err=1, rsp_rdata=0; next request proceeds normally.
